// File: rtl/seg_scroll_pkg.sv
// Shared types and constants for the scrolling seven-segment display controller.
package seg_scroll_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      RUN  = 2'd3
   } state_t;

   // Character code shown as an unlit digit; codes 10-15 all decode to blank.
   localparam logic [3:0] BLANK_CODE = 4'hA;

   // Active-low segment patterns {a,b,c,d,e,f,g,dp}, indexed by character code.
   // Entry 15 is the leftmost element of the concatenation, entry 0 the rightmost.
   localparam logic [15:0][7:0] SEG_LUT = {
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
      8'h09, 8'h01, 8'h1B, 8'h41, 8'h49,
      8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
   };

   // Table lookup helper so every user decodes through the same constant.
   function automatic logic [7:0] segLookup(input logic [3:0] code);
      return SEG_LUT[code];
   endfunction

endpackage

// File: rtl/seg_scroll_ctrl_if.sv
// Valid/ready character write port feeding the message buffer.
interface seg_scroll_ctrl_if;

   logic       wr_valid;
   logic       wr_ready;
   logic [3:0] wr_char;
   logic       wr_last;

   modport master (
      output wr_valid,
      output wr_char,
      output wr_last,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_char,
      input  wr_last,
      output wr_ready
   );

endinterface

// File: rtl/seg7_decode_n.sv
// Combinational 4-bit character code to active-low seven-segment pattern.
module seg7_decode_n
   import seg_scroll_pkg::*;
(
   input  logic [3:0] i_char,
   output logic [7:0] o_seg
);

   // Straight lookup; blank codes come out as all segments off.
   always_comb begin
      o_seg = segLookup(i_char);
   end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Message buffer, scroll sequencer and digit scanner for the 8-digit display.
module seg_scroll_ctrl
   import seg_scroll_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int STEP_DIV  = 50000000,
   parameter int MSG_DEPTH = 16
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   seg_scroll_ctrl_if.slave     wr,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear,
   output logic                 busy,
   output logic                 chk_light,
   output logic [7:0]           light_switch,
   output logic [7:0]           data
);

   localparam int IDX_W  = $clog2(MSG_DEPTH);
   localparam int LEN_W  = IDX_W + 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   state_t             r_state;
   state_t             w_nextState;

   logic [LEN_W-1:0]   r_wrPtr;
   logic [LEN_W-1:0]   r_msgLen;
   logic [LEN_W-1:0]   r_offset;
   logic [STEP_W-1:0]  r_stepCnt;
   logic [SCAN_W-1:0]  r_scanCnt;
   logic [2:0]         r_digitIdx;
   logic               r_chkLight;
   logic [7:0]         r_anode;
   logic [7:0]         r_seg;
   logic [3:0]         r_buf [MSG_DEPTH];

   logic               w_wrReady;
   logic               w_wrFire;
   logic               w_lastWrite;
   logic               w_stepTc;
   logic               w_scanTc;
   logic [LEN_W-1:0]   w_ringLen;
   logic [LEN_W-1:0]   w_offsetInc;
   logic [LEN_W-1:0]   w_offsetNext;
   logic [2:0]         w_rev;
   logic [LEN_W-1:0]   w_pos;
   logic [LEN_W-1:0]   w_posMod;
   logic [3:0]         w_char;
   logic [7:0]         w_segCode;

   // A write lands only when the port is open and clear is not dropping it.
   assign w_wrFire    = wr.wr_valid && w_wrReady && !clear;
   assign w_lastWrite = w_wrFire && (wr.wr_last || (r_wrPtr == LEN_W'(MSG_DEPTH - 1)));
   assign w_stepTc    = (r_stepCnt == STEP_W'(STEP_DIV - 1));
   assign w_scanTc    = (r_scanCnt == SCAN_W'(SCAN_DIV - 1));
   assign wr.wr_ready = w_wrReady;
   assign chk_light   = r_chkLight;
   assign light_switch = r_anode;
   assign data        = r_seg;

   // Short messages still scroll across a full 8-digit ring padded with blanks.
   assign w_ringLen    = (r_msgLen > LEN_W'(8)) ? r_msgLen : LEN_W'(8);
   assign w_offsetInc  = r_offset + LEN_W'(1);
   assign w_offsetNext = (w_offsetInc >= w_ringLen) ? '0 : w_offsetInc;

   // Digit k shows position offset+7-k; the sum stays below 2L so one subtract wraps it.
   always_comb begin
      w_rev    = 3'd7 - r_digitIdx;
      w_pos    = r_offset + {{(LEN_W-3){1'b0}}, w_rev};
      w_posMod = (w_pos >= w_ringLen) ? (w_pos - w_ringLen) : w_pos;
      if ((r_state == IDLE) || (w_posMod >= r_msgLen)) begin
         w_char = BLANK_CODE;
      end else begin
         w_char = r_buf[w_posMod[IDX_W-1:0]];
      end
   end

   seg7_decode_n u_decode (
      .i_char (w_char),
      .o_seg  (w_segCode)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next state: clear beats stop, stop beats start, start beats writes.
   always_comb begin
      w_nextState = r_state;
      if (clear) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: if (w_wrFire)    w_nextState = w_lastWrite ? HOLD : LOAD;
            LOAD: if (w_lastWrite) w_nextState = HOLD;
            HOLD: if (start)       w_nextState = RUN;
            RUN:  if (stop)        w_nextState = HOLD;
            default:               w_nextState = IDLE;
         endcase
      end
   end

   // FSM outputs decoded from the current state only.
   always_comb begin
      busy      = (r_state == RUN);
      w_wrReady = (r_state == IDLE) || (r_state == LOAD);
   end

   // Write pointer advances per accepted character; the final one fixes the length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr  <= '0;
         r_msgLen <= '0;
      end else if (clear) begin
         r_wrPtr  <= '0;
         r_msgLen <= '0;
      end else if (w_wrFire) begin
         r_wrPtr <= r_wrPtr + LEN_W'(1);
         if (w_lastWrite) begin
            r_msgLen <= r_wrPtr + LEN_W'(1);
         end
      end
   end

   // Message storage has no reset; stale entries are hidden by the length check.
   always_ff @(posedge clk) begin
      if (w_wrFire) begin
         r_buf[r_wrPtr[IDX_W-1:0]] <= wr.wr_char;
      end
   end

   // Step timer runs only in RUN and advances the scroll offset on each wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stepCnt  <= '0;
         r_offset   <= '0;
         r_chkLight <= 1'b0;
      end else begin
         r_chkLight <= 1'b0;
         if (clear) begin
            r_stepCnt <= '0;
            r_offset  <= '0;
         end else if (r_state == RUN) begin
            if (stop) begin
               r_stepCnt <= '0;
               r_offset  <= '0;
            end else if (w_stepTc) begin
               r_stepCnt  <= '0;
               r_offset   <= w_offsetNext;
               r_chkLight <= 1'b1;
            end else begin
               r_stepCnt <= r_stepCnt + STEP_W'(1);
            end
         end else begin
            r_stepCnt <= '0;
         end
      end
   end

   // Scanner: each slot end latches anode and segments for the current digit together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scanCnt  <= '0;
         r_digitIdx <= '0;
         r_anode    <= 8'hFF;
         r_seg      <= 8'hFF;
      end else if (w_scanTc) begin
         r_scanCnt  <= '0;
         r_digitIdx <= r_digitIdx + 3'd1;
         r_anode    <= ~(8'h01 << r_digitIdx);
         r_seg      <= w_segCode;
      end else begin
         r_scanCnt <= r_scanCnt + SCAN_W'(1);
      end
   end

endmodule

// File: doc/seg_scroll_ctrl.md
Name: seg_scroll_ctrl

Overview:
- Controller for the 8-digit multiplexed seven-segment display on Nexys4 DDR.
- Accepts a message of up to MSG_DEPTH 4-bit character codes over a valid/ready write port.
- Holds the message statically or scrolls it leftward at a programmable step rate.
- Owns digit scanning: sole driver of anode and segment lines, active-low at the board pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit scan slot.
- STEP_DIV, 50000000: clk cycles per scroll step.
- MSG_DEPTH, 16: message buffer entries; power of 2, minimum 8.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write character offered
- wr_ready  out  1  controller can accept a character
- wr_char  in  4  character code; 0-9 are digits, 10-15 are blank
- wr_last  in  1  qualifies wr_char as the final character of the message
- start  in  1  single-cycle pulse: begin scrolling
- stop  in  1  single-cycle pulse: halt scrolling
- clear  in  1  single-cycle pulse: discard the message
- busy  out  1  high while in RUN
- chk_light  out  1  one-cycle pulse on each scroll step
- light_switch  out  8  anodes, active-low one-hot; bit 0 is the rightmost digit
- data  out  8  segments, active-low; bit 7 is a … bit 1 is g, bit 0 is dp (dp is always off)

Behaviour:
- Reset values, asynchronous on rst_n low:
  - state IDLE; wr_ptr, msg_len, offset, step counter and scan counter all 0.
  - light_switch=8'hFF, data=8'hFF, busy=0, chk_light=0, wr_ready=1.
- Write handshake:
  - A transfer occurs on a rising edge with wr_valid && wr_ready.
  - wr_ready=1 in IDLE and LOAD only. wr_char is written to buf[wr_ptr], then wr_ptr increments.
- State IDLE:
  - All digits show blank.
  - An accepted write moves to LOAD. If that write has wr_last, go directly to HOLD.
  - start and stop are ignored.
- State LOAD:
  - Accepts writes.
  - Moves to HOLD with msg_len=wr_ptr+1 when the accepted write has wr_last, or when the write fills entry MSG_DEPTH-1.
  - start and stop are ignored.
- State HOLD:
  - Displays the message at the current offset without stepping.
  - start moves to RUN, and the step counter restarts at 0.
- State RUN:
  - The step counter counts 0..STEP_DIV-1.
  - At terminal count: offset <= (offset+1) mod L, chk_light pulses for 1 cycle, and the counter wraps.
  - stop moves to HOLD with offset=0.
- clear:
  - From any state, go to IDLE next cycle with wr_ptr=0, msg_len=0, offset=0. Buffer contents need not be erased.
  - Priority: clear > stop > start > write. A write coincident with clear is dropped.
- Virtual ring length L = max(msg_len, 8). Buffer positions >= msg_len read as blank, so short messages are padded with blanks.
- Digit mapping: digit k (k=0 rightmost) shows buf[(offset + 7 - k) mod L]. Digit 7 therefore shows buf[offset], and text moves leftward.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 in every state.
  - At terminal count, digit index advances 0→1→…→7→0.
  - On that edge, light_switch and data are registered together: light_switch = ~(1<<idx), data = decode(char).
  - There is no combinational path from input to output. Changes in offset or state appear on the next scan slot.
- Decode table, active-low values, 8'hFF for 10-15:
  - 0 → 8'h03, 1 → 8'h9F, 2 → 8'h25, 3 → 8'h0D, 4 → 8'h99
  - 5 → 8'h49, 6 → 8'h41, 7 → 8'h1B, 8 → 8'h01, 9 → 8'h09
- Widths:
  - Counters are sized $clog2(div).
  - offset and msg_len are $clog2(MSG_DEPTH)+1 bits.
  - Modulo on L uses compare-and-subtract, never a divider.
- A reset asserted mid-RUN or mid-LOAD is taken immediately. The message is lost and a new load is required.

Decomposition:
- Package seg_scroll_pkg holds:
  - the state enum (IDLE, LOAD, HOLD, RUN);
  - the constant BLANK_CODE=4'hA;
  - the 16-entry active-low segment lookup constant.
- Sub-module seg7_decode_n: purely combinational 4-bit-to-8-bit active-low decoder using the package table.
- All sequential logic lives in seg_scroll_ctrl.

Test Plan (SCAN_DIV=4, STEP_DIV=40, MSG_DEPTH=16):
- Reset held, then released with no input → light_switch steps FE, FD, FB … 7F every 4 cycles; data=FF on every digit; wr_ready=1; busy=0.
- Write 1,0,1,1,0,5,1,2 with wr_last on the final 2 → HOLD; the digit whose anode bit 7 is low shows 8'h9F ('1'); the digit with bit 0 low shows 8'h25 ('2'); wr_ready=0.
- From that state, pulse start → busy=1; chk_light pulses at 40-cycle intervals; after one step digit 7 shows '0' (8'h03) and digit 0 shows '1' (8'h9F); after 8 steps the original image returns.
- Write 3 characters (7,8,9, last) then start → L=8; the digits show 7,8,9 followed by 5 blanks; the pattern scrolls and wraps after 8 steps.
- Write 16 characters without wr_last → HOLD after the 16th write with msg_len=16; a 17th wr_valid is not accepted (wr_ready=0).
- Mid-RUN, pulse stop and start in the same cycle → HOLD with offset 0; then pulse clear and start together → IDLE, all digits blank, busy=0; then assert rst_n low mid-scan → outputs go to FF asynchronously.
